// File: rtl/micro_seq_pkg.sv
// Shared types and field helpers for the microprogrammed sequencer.
package micro_seq_pkg;

    // Width of the branch-instruction field at the top of every microword.
    localparam int BI_W = 3;

    // Branch instructions, in the order they are encoded in the bi field.
    typedef enum logic [BI_W-1:0] {
        BR_NEXT  = 3'd0,
        BR_WAIT  = 3'd1,
        BR_BNZ   = 3'd2,
        BR_RESET = 3'd3,
        BR_B     = 3'd4,
        BR_BN    = 3'd5,
        BR_CALL  = 3'd6,
        BR_RET   = 3'd7
    } br_op_e;

    // Sequencer run state: RUN until a stack error, then FAULT until reset.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } seq_state_e;

    // Full microword width for a given address and control-field width.
    function automatic int mwWidth(input int addrW, input int ctrlW);
        return BI_W + addrW + ctrlW;
    endfunction

    // Bit offset of the branch-address field (it sits directly above ctrl).
    function automatic int baLsb(input int ctrlW);
        return ctrlW;
    endfunction

endpackage

// File: rtl/micro_stack.sv
// Return-address LIFO for CALL/RET. Push and pop are never requested together.
module micro_stack
    import micro_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  r_sp;
    logic [W-1:0]     r_mem [DEPTH];
    logic [IDX_W-1:0] w_wrIdx;
    logic [IDX_W-1:0] w_topIdx;

    // Write slot is the current pointer; the top of stack is one below it.
    always_comb begin
        w_wrIdx  = IDX_W'(r_sp);
        w_topIdx = IDX_W'(r_sp - SP_W'(1));
        o_full   = (r_sp == SP_W'(DEPTH));
        o_empty  = (r_sp == '0);
        o_top    = r_mem[w_topIdx];
    end

    // Stack pointer; reset empties the stack without touching entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Entry storage needs no reset; only slots below the pointer are ever read.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wrIdx] <= i_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed controller: writable store, uPC, branch unit with return stack.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int CTRL_W      = 17,
    parameter int STACK_DEPTH = 4,
    parameter     INIT_FILE   = "",
    localparam int MW_W       = BI_W + ADDR_W + CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              zero,
    input  logic              neg,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [MW_W-1:0]   prog_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [ADDR_W-1:0] upc,
    output logic              fault
);

    localparam int WORDS = 2 ** ADDR_W;

    logic [MW_W-1:0]   r_store [WORDS];
    logic [ADDR_W-1:0] r_upc;
    seq_state_e        r_state;

    logic [MW_W-1:0]   w_word;
    br_op_e            w_bi;
    logic [ADDR_W-1:0] w_ba;
    logic [CTRL_W-1:0] w_ctrlField;
    logic [ADDR_W-1:0] w_upcInc;
    logic [ADDR_W-1:0] w_nextUpc;
    seq_state_e        w_nextState;
    logic              w_run;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_stackTop;
    logic              w_full;
    logic              w_empty;

    micro_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_upcInc),
        .o_top   (w_stackTop),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Asynchronous store read: the word at uPC drives the branch unit and ctrl directly.
    always_comb begin
        w_word      = r_store[r_upc];
        w_bi        = br_op_e'(w_word[MW_W-1 -: BI_W]);
        w_ba        = w_word[baLsb(CTRL_W) +: ADDR_W];
        w_ctrlField = w_word[CTRL_W-1:0];
        w_upcInc    = r_upc + ADDR_W'(1);
        w_run       = en && (r_state == ST_RUN);
        ctrl        = w_run ? w_ctrlField : '0;
        upc         = r_upc;
        fault       = (r_state == ST_FAULT);
    end

    // Branch mux and fault detection; a stack error freezes uPC and parks in FAULT.
    always_comb begin
        w_nextUpc   = r_upc;
        w_nextState = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (w_run) begin
            case (w_bi)
                BR_NEXT:  w_nextUpc = w_upcInc;
                BR_WAIT:  w_nextUpc = start ? w_upcInc : r_upc;
                BR_BNZ:   w_nextUpc = zero ? w_upcInc : w_ba;
                BR_RESET: w_nextUpc = '0;
                BR_B:     w_nextUpc = w_ba;
                BR_BN:    w_nextUpc = neg ? w_ba : w_upcInc;
                BR_CALL: begin
                    if (w_full) begin
                        w_nextState = ST_FAULT;
                    end else begin
                        w_push    = 1'b1;
                        w_nextUpc = w_ba;
                    end
                end
                BR_RET: begin
                    if (w_empty) begin
                        w_nextState = ST_FAULT;
                    end else begin
                        w_pop     = 1'b1;
                        w_nextUpc = w_stackTop;
                    end
                end
                default:  w_nextUpc = w_upcInc;
            endcase
        end
    end

    // uPC and run/fault state; reset restarts at word 0 but leaves the store alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc   <= '0;
            r_state <= ST_RUN;
        end else begin
            r_upc   <= w_nextUpc;
            r_state <= w_nextState;
        end
    end

    // Microcode writes are only accepted while sequencing is paused.
    always_ff @(posedge clk) begin
        if (prog_we && !en) begin
            r_store[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench: behavioural model of the sequencer plus directed and random runs.
module tb_micro_sequencer;

    localparam int AW    = 4;
    localparam int CW    = 17;
    localparam int SD    = 4;
    localparam int MW    = 3 + AW + CW;
    localparam int WORDS = 16;

    localparam int OP_NEXT = 0, OP_WAIT = 1, OP_BNZ = 2, OP_RESET = 3;
    localparam int OP_B    = 4, OP_BN   = 5, OP_CALL = 6, OP_RET  = 7;

    localparam int C_DONE = 1, C_LDA = 2, C_LDB = 4, C_SUBA = 8, C_SUBB = 16, C_OE = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, start, zero, neg, prog_we;
    logic [AW-1:0] prog_addr;
    logic [MW-1:0] prog_data;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] upc;
    logic          fault;

    logic [MW-1:0] mMem [WORDS];
    int            mUpc;
    int            mStack [$];
    bit            mFault;
    bit            checkOn;
    int            checks;
    int            failures;

    logic [MW-1:0] prog [WORDS];
    int            seqCall [6];
    int            seqNest [12];
    int            dA, dB, oldA, oldB, cNow;
    bit            gcdDone;

    always #5 clk = ~clk;

    micro_sequencer #(
        .ADDR_W      (AW),
        .CTRL_W      (CW),
        .STACK_DEPTH (SD),
        .INIT_FILE   ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .zero      (zero),
        .neg       (neg),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .ctrl      (ctrl),
        .upc       (upc),
        .fault     (fault)
    );

    function automatic logic [MW-1:0] mkWord(input int bi, input int ba, input int c);
        return {3'(bi), 4'(ba), 17'(c)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mUpc   = 0;
        mFault = 0;
        mStack.delete();
    endtask

    // One clock edge of the sequencer, expressed directly from the branch rules.
    task automatic modelEdge();
        int bi, ba, nxt;
        if (prog_we && !en) mMem[prog_addr] = prog_data;
        else if (en && !mFault) begin
            bi  = int'(mMem[mUpc][MW-1 -: 3]);
            ba  = int'(mMem[mUpc][MW-4 -: AW]);
            nxt = (mUpc + 1) % WORDS;
            case (bi)
                OP_NEXT:  mUpc = nxt;
                OP_WAIT:  if (start) mUpc = nxt;
                OP_BNZ:   mUpc = zero ? nxt : ba;
                OP_RESET: mUpc = 0;
                OP_B:     mUpc = ba;
                OP_BN:    mUpc = neg ? ba : nxt;
                OP_CALL:  if (mStack.size() == SD) mFault = 1;
                          else begin mStack.push_back(nxt); mUpc = ba; end
                default:  if (mStack.size() == 0) mFault = 1;
                          else mUpc = mStack.pop_back();
            endcase
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return just after the falling edge.
    task automatic applyStimulus(input logic iEn, input logic iStart, input logic iZero,
                                 input logic iNeg, input logic iWe, input logic [AW-1:0] iAddr,
                                 input logic [MW-1:0] iData);
        en        = iEn;
        start     = iStart;
        zero      = iZero;
        neg       = iNeg;
        prog_we   = iWe;
        prog_addr = iAddr;
        prog_data = iData;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        #1;
    endtask

    task automatic step(input logic iStart);
        applyStimulus(1'b1, iStart, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic writeWord(input int addr, input logic [MW-1:0] data);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(addr), data);
    endtask

    task automatic loadProgram();
        for (int i = 0; i < WORDS; i++) writeWord(i, prog[i]);
    endtask

    // Mid-cycle reset pulse; uPC and fault must clear without waiting for a clock edge.
    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_upc", 32'(upc), 32'd0);
        checkOutput("async_rst_fault", 32'(fault), 32'd0);
        modelReset();
        #1;
        rst_n = 1'b1;
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        logic [CW-1:0] expCtrl;
        if (checkOn) begin
            expCtrl = (en && !mFault) ? mMem[mUpc][CW-1:0] : '0;
            checkOutput("upc", 32'(upc), 32'(mUpc));
            checkOutput("fault", 32'(fault), 32'(mFault));
            checkOutput("ctrl", 32'(ctrl), 32'(expCtrl));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        checkOn  = 0;
        for (int i = 0; i < WORDS; i++) mMem[i] = '0;
        modelReset();
        rst_n = 1'b0;
        en = 0; start = 0; zero = 0; neg = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
        @(negedge clk);
        #1;
        checkOutput("reset_upc", 32'(upc), 32'd0);
        checkOutput("reset_fault", 32'(fault), 32'd0);
        checkOutput("reset_ctrl", 32'(ctrl), 32'd0);
        rst_n   = 1'b1;
        checkOn = 1;

        // GCD microprogram: wait, load, compare, subtract loop, done at word 4.
        for (int i = 0; i < WORDS; i++) prog[i] = mkWord(OP_RESET, 0, 0);
        prog[0] = mkWord(OP_WAIT, 0, 0);
        prog[1] = mkWord(OP_NEXT, 0, C_LDA | C_LDB);
        prog[2] = mkWord(OP_BNZ, 5, 0);
        prog[3] = mkWord(OP_NEXT, 0, 0);
        prog[4] = mkWord(OP_B, 0, C_DONE | C_OE);
        prog[5] = mkWord(OP_BN, 7, 0);
        prog[6] = mkWord(OP_B, 2, C_SUBA);
        prog[7] = mkWord(OP_B, 2, C_SUBB);
        prog[8] = mkWord(OP_NEXT, 0, 0);
        loadProgram();
        dA = 0;
        dB = 0;
        gcdDone = 0;
        for (int k = 0; k < 60; k++) begin
            if (ctrl[0]) begin
                checkOutput("gcd_done_upc", 32'(upc), 32'd4);
                checkOutput("gcd_result", 32'(dA), 32'd4);
                gcdDone = 1;
                break;
            end
            cNow = mFault ? 0 : int'(mMem[mUpc][CW-1:0]);
            applyStimulus(1'b1, k == 0, dA == dB, dA < dB, 1'b0, '0, '0);
            oldA = dA;
            oldB = dB;
            if ((cNow & C_LDA) != 0) dA = 12;
            if ((cNow & C_LDB) != 0) dB = 8;
            if ((cNow & C_SUBA) != 0) dA = oldA - oldB;
            if ((cNow & C_SUBB) != 0) dB = oldB - oldA;
        end
        if (!gcdDone) begin
            checks++;
            failures++;
            $display("[TB] FAIL gcd_timeout: done never seen, upc=%0d required 4", upc);
        end

        // Single CALL/RET: 3 -> 10 -> 4.
        pulseReset();
        for (int i = 0; i < WORDS; i++) prog[i] = mkWord(OP_B, 4, 0);
        prog[0]  = mkWord(OP_NEXT, 0, 1);
        prog[1]  = mkWord(OP_NEXT, 0, 2);
        prog[2]  = mkWord(OP_NEXT, 0, 3);
        prog[3]  = mkWord(OP_CALL, 10, 'h11);
        prog[10] = mkWord(OP_RET, 0, 'h22);
        loadProgram();
        seqCall = '{1, 2, 3, 10, 4, 4};
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            checkOutput("call_seq", 32'(upc), 32'(seqCall[i]));
        end

        // Four nested calls unwinding in LIFO order.
        pulseReset();
        prog[3]  = mkWord(OP_CALL, 8, 0);
        prog[8]  = mkWord(OP_CALL, 10, 0);
        prog[10] = mkWord(OP_CALL, 12, 0);
        prog[12] = mkWord(OP_CALL, 14, 0);
        prog[14] = mkWord(OP_RET, 0, 0);
        prog[13] = mkWord(OP_RET, 0, 0);
        prog[11] = mkWord(OP_RET, 0, 0);
        prog[9]  = mkWord(OP_RET, 0, 0);
        loadProgram();
        seqNest = '{1, 2, 3, 8, 10, 12, 14, 13, 11, 9, 4, 4};
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            checkOutput("nest_seq", 32'(upc), 32'(seqNest[i]));
        end

        // Fifth nested call overflows the stack.
        writeWord(14, mkWord(OP_CALL, 15, 'h1ABCD));
        pulseReset();
        for (int i = 0; i < 7; i++) step(1'b0);
        checkOutput("ovf_pre_upc", 32'(upc), 32'd14);
        step(1'b0);
        checkOutput("ovf_fault", 32'(fault), 32'd1);
        checkOutput("ovf_upc", 32'(upc), 32'd14);
        checkOutput("ovf_ctrl", 32'(ctrl), 32'd0);
        step(1'b1);
        checkOutput("ovf_frozen", 32'(upc), 32'd14);
        pulseReset();

        // RET straight out of reset underflows.
        writeWord(0, mkWord(OP_RET, 0, 'h155));
        pulseReset();
        step(1'b0);
        checkOutput("unf_fault", 32'(fault), 32'd1);
        checkOutput("unf_upc", 32'(upc), 32'd0);
        checkOutput("unf_ctrl", 32'(ctrl), 32'd0);

        // Store writes: paused writes land, writes while running are dropped.
        pulseReset();
        writeWord(0, mkWord(OP_B, 5, 0));
        writeWord(5, mkWord(OP_B, 5, 'h0F0F0));
        step(1'b0);
        checkOutput("prog_readback", 32'(ctrl), 32'h0F0F0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, AW'(5), mkWord(OP_B, 5, 'h1234));
        checkOutput("prog_ignored", 32'(ctrl), 32'h0F0F0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, AW'(5), mkWord(OP_B, 5, 'h0AAAA));
        checkOutput("prog_gated", 32'(ctrl), 32'd0);
        step(1'b0);
        checkOutput("prog_live", 32'(ctrl), 32'h0AAAA);

        // NEXT at the top word wraps to 0.
        writeWord(0, mkWord(OP_B, 15, 0));
        writeWord(15, mkWord(OP_NEXT, 0, 7));
        pulseReset();
        step(1'b0);
        checkOutput("wrap_top", 32'(upc), 32'd15);
        step(1'b0);
        checkOutput("wrap_zero", 32'(upc), 32'd0);

        // Reset asserted while parked on a WAIT word.
        writeWord(0, mkWord(OP_NEXT, 0, 0));
        writeWord(1, mkWord(OP_WAIT, 0, 3));
        pulseReset();
        step(1'b0);
        step(1'b0);
        checkOutput("wait_hold", 32'(upc), 32'd1);
        pulseReset();

        // Randomised microcode and inputs against the model.
        for (int i = 0; i < WORDS; i++)
            writeWord(i, mkWord($urandom_range(0, 7), $urandom_range(0, 15), int'($urandom)));
        pulseReset();
        for (int k = 0; k < 1500; k++) begin
            logic rEn;
            rEn = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0) pulseReset();
            applyStimulus(rEn, 1'($urandom), 1'($urandom), 1'($urandom),
                          !rEn && ($urandom_range(0, 1) == 1), AW'($urandom),
                          mkWord($urandom_range(0, 7), $urandom_range(0, 15), int'($urandom)));
        end

        checkOn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
